// File: rtl/pg_gen_stage_if.sv
// rtl/pg_gen_stage_if.sv - operand handshake and P/G result bundle for pg_gen_stage (p_par present under PG_PARITY_EN)
interface pg_gen_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             gin;
    logic             out_valid;
    logic [1:0]       phase;
`ifdef PG_PARITY_EN
    logic             p_par;

    modport master (
        output in_valid, a, b, cin, sub,
        input  in_ready, p, g, gin, out_valid, phase, p_par
    );

    modport slave (
        input  in_valid, a, b, cin, sub,
        output in_ready, p, g, gin, out_valid, phase, p_par
    );
`else
    modport master (
        output in_valid, a, b, cin, sub,
        input  in_ready, p, g, gin, out_valid, phase
    );

    modport slave (
        input  in_valid, a, b, cin, sub,
        output in_ready, p, g, gin, out_valid, phase
    );
`endif
endinterface

// File: rtl/pg_gen_stage.sv
// rtl/pg_gen_stage.sv - operand staging and propagate/generate stage with 4-phase power-clock sequencing
// Optional p_par parity output enabled by defining PG_PARITY_EN.
module pg_gen_stage #(
    parameter int WIDTH       = 32,
    parameter int HOLD_CYCLES = 2
) (
    input  logic          clkpos,
    input  logic          rst,
    pg_gen_stage_if.slave bus
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EVAL    = 2'd1,
        S_HOLD    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    hold_cnt;

    logic [WIDTH-1:0] work_a;
    logic [WIDTH-1:0] work_b;
    logic             work_cin;
    logic             work_sub;

    logic [WIDTH-1:0] buf_a;
    logic [WIDTH-1:0] buf_b;
    logic             buf_cin;
    logic             buf_sub;
    logic             buf_full;

    logic             ready;
    logic             transfer;
    logic             active;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_int;
    logic [WIDTH-1:0] g_int;
    logic             gin_int;
    logic             valid_int;

    assign ready    = (state == S_IDLE) | ~buf_full;
    assign transfer = bus.in_valid & ready;

    always_ff @(posedge clkpos) begin
        if (rst) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            work_a   <= '0;
            work_b   <= '0;
            work_cin <= 1'b0;
            work_sub <= 1'b0;
            buf_a    <= '0;
            buf_b    <= '0;
            buf_cin  <= 1'b0;
            buf_sub  <= 1'b0;
            buf_full <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (transfer) begin
                        work_a   <= bus.a;
                        work_b   <= bus.b;
                        work_cin <= bus.cin;
                        work_sub <= bus.sub;
                        state    <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    hold_cnt <= CW'(HOLD_CYCLES - 1);
                    state    <= S_HOLD;
                    if (transfer) begin
                        buf_a    <= bus.a;
                        buf_b    <= bus.b;
                        buf_cin  <= bus.cin;
                        buf_sub  <= bus.sub;
                        buf_full <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= S_RECOVER;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                    if (transfer) begin
                        buf_a    <= bus.a;
                        buf_b    <= bus.b;
                        buf_cin  <= bus.cin;
                        buf_sub  <= bus.sub;
                        buf_full <= 1'b1;
                    end
                end
                S_RECOVER: begin
                    // A transfer here only happens with an empty buffer; it is
                    // written and consumed on the same edge, so it goes straight in.
                    if (buf_full) begin
                        work_a   <= buf_a;
                        work_b   <= buf_b;
                        work_cin <= buf_cin;
                        work_sub <= buf_sub;
                        buf_full <= 1'b0;
                        state    <= S_EVAL;
                    end else if (transfer) begin
                        work_a   <= bus.a;
                        work_b   <= bus.b;
                        work_cin <= bus.cin;
                        work_sub <= bus.sub;
                        state    <= S_EVAL;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Results come only from the working register and are zeroed outside
    // EVAL/HOLD so downstream adiabatic cells discharge in RECOVER.
    assign active    = (state == S_EVAL) | (state == S_HOLD);
    assign b_eff     = work_sub ? ~work_b : work_b;
    assign p_int     = active ? (work_a ^ b_eff) : '0;
    assign g_int     = active ? (work_a & b_eff) : '0;
    assign gin_int   = active & (work_sub | work_cin);
    assign valid_int = (state == S_HOLD);

    assign bus.in_ready  = ready;
    assign bus.p         = p_int;
    assign bus.g         = g_int;
    assign bus.gin       = gin_int;
    assign bus.out_valid = valid_int;
    assign bus.phase     = state;

`ifdef PG_PARITY_EN
    assign bus.p_par = valid_int & (^p_int);
`endif

endmodule

// File: tb/tb_pg_gen_stage.sv
// tb/tb_pg_gen_stage.sv - directed table-driven bench for pg_gen_stage (WIDTH=8, HOLD_CYCLES=2)
module tb_pg_gen_stage;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    pg_gen_stage_if #(.WIDTH(8)) bus ();

    pg_gen_stage #(
        .WIDTH       (8),
        .HOLD_CYCLES (2)
    ) dut (
        .clkpos (clk),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] ep;
        logic [7:0] eg;
        logic       egin;
        logic       epar;
    } vec_t;

    vec_t vecs[6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_par(input string name, input logic exp);
`ifdef PG_PARITY_EN
        check(name, {31'd0, bus.p_par}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("unreachable %s", name);
`endif
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.cin      = 1'($urandom);
        bus.sub      = 1'($urandom);
    endtask

    task automatic run_op(input int i);
        drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
        check($sformatf("v%0d_ready", i), {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        idle_inputs();
        check($sformatf("v%0d_eval_phase", i), {30'd0, bus.phase}, 32'd1);
        check($sformatf("v%0d_eval_valid", i), {31'd0, bus.out_valid}, 32'd0);
        check($sformatf("v%0d_eval_p", i), {24'd0, bus.p}, {24'd0, vecs[i].ep});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            idle_inputs();
            check($sformatf("v%0d_hold%0d_phase", i, k), {30'd0, bus.phase}, 32'd2);
            check($sformatf("v%0d_hold%0d_valid", i, k), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("v%0d_hold%0d_p", i, k), {24'd0, bus.p}, {24'd0, vecs[i].ep});
            check($sformatf("v%0d_hold%0d_g", i, k), {24'd0, bus.g}, {24'd0, vecs[i].eg});
            check($sformatf("v%0d_hold%0d_gin", i, k), {31'd0, bus.gin}, {31'd0, vecs[i].egin});
            check_par($sformatf("v%0d_hold%0d_par", i, k), vecs[i].epar);
        end
        @(negedge clk);
        check($sformatf("v%0d_rec_phase", i), {30'd0, bus.phase}, 32'd3);
        check($sformatf("v%0d_rec_pg", i), {15'd0, bus.p, bus.g, bus.gin}, 32'd0);
        check($sformatf("v%0d_rec_valid", i), {31'd0, bus.out_valid}, 32'd0);
        check_par($sformatf("v%0d_rec_par", i), 1'b0);
        @(negedge clk);
        check($sformatf("v%0d_idle_phase", i), {30'd0, bus.phase}, 32'd0);
        check($sformatf("v%0d_idle_ready", i), {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        //              a      b      cin   sub   p      g      gin   par
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h66, 8'h18, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'hEE, 8'h10, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'hFE, 8'h01, 1'b1, 1'b1};
        vecs[3] = '{8'hA5, 8'hA5, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = 8'h00;
        bus.b        = 8'h00;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_phase", {30'd0, bus.phase}, 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_pg", {15'd0, bus.p, bus.g, bus.gin}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        check_par("rst_par", 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_op(i);

        // back-to-back: op2 buffered during EVAL, no IDLE between ops
        drive(8'hFF, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        drive(8'h0F, 8'hF0, 1'b0, 1'b0);
        check("b2b_eval_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        idle_inputs();
        check("b2b_hold_ready", {31'd0, bus.in_ready}, 32'd0);
        check("b2b_op1_p", {24'd0, bus.p}, 32'hFE);
        check("b2b_op1_g", {24'd0, bus.g}, 32'h01);
        @(negedge clk);
        check("b2b_hold2_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("b2b_rec_phase", {30'd0, bus.phase}, 32'd3);
        check("b2b_rec_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("b2b_op2_eval", {30'd0, bus.phase}, 32'd1);
        check("b2b_op2_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("b2b_op2_hold%0d_valid", k), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("b2b_op2_hold%0d_p", k), {24'd0, bus.p}, 32'hFF);
            check($sformatf("b2b_op2_hold%0d_g", k), {24'd0, bus.g}, 32'h00);
        end
        @(negedge clk);
        check("b2b_op2_rec", {30'd0, bus.phase}, 32'd3);
        @(negedge clk);
        check("b2b_idle", {30'd0, bus.phase}, 32'd0);

        // transfer during RECOVER with empty buffer goes straight to EVAL
        drive(8'h5A, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rt_rec_phase", {30'd0, bus.phase}, 32'd3);
        check("rt_rec_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(8'h01, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        idle_inputs();
        check("rt_eval", {30'd0, bus.phase}, 32'd1);
        @(negedge clk);
        check("rt_hold_p", {24'd0, bus.p}, 32'h01);
        check("rt_hold_g", {24'd0, bus.g}, 32'h00);
        check("rt_hold_gin", {31'd0, bus.gin}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rt_idle", {30'd0, bus.phase}, 32'd0);

        // reset mid-HOLD with a buffered op: the buffered op must vanish
        drive(8'h33, 8'h0C, 1'b0, 1'b0);
        @(negedge clk);
        drive(8'hAA, 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        idle_inputs();
        check("mr_hold_phase", {30'd0, bus.phase}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_phase", {30'd0, bus.phase}, 32'd0);
        check("mr_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mr_pg", {15'd0, bus.p, bus.g, bus.gin}, 32'd0);
        check("mr_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("mr_quiet%0d", k), {29'd0, bus.out_valid, bus.phase}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
